// File: rtl/wb_ram_slave.sv
// rtl/wb_ram_slave.sv - Wishbone B3 classic 32-bit RAM slave with wait states and range error
module wb_ram_slave #(
    parameter int    ADDR_WIDTH  = 10,
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;

    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic [31:0]           dat_q;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

    logic req;
    assign req = wb_cyc_i & wb_stb_i;

    // With no wait states the response is produced on the request edge itself,
    // so the live bus fields are used instead of the latched copies.
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic                  cur_we;
    logic [3:0]            cur_sel;
    logic [31:0]           cur_dat;
    assign cur_idx = (state == IDLE) ? wb_adr_i[ADDR_WIDTH+1:2] : idx_q;
    assign cur_we  = (state == IDLE) ? wb_we_i  : we_q;
    assign cur_sel = (state == IDLE) ? wb_sel_i : sel_q;
    assign cur_dat = (state == IDLE) ? wb_dat_i : dat_q;

    logic in_range;
    assign in_range = (32'(cur_idx) < 32'(DEPTH_WORDS));

    logic go_resp;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        go_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_next = RESP;
                        go_resp    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (cnt == 4'd0) begin
                    state_next = RESP;
                    go_resp    = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'd0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= 4'd0;
            dat_q    <= 32'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            wb_ack_o <= go_resp & in_range;
            wb_err_o <= go_resp & ~in_range;
            if (state == IDLE && req) begin
                idx_q <= wb_adr_i[ADDR_WIDTH+1:2];
                we_q  <= wb_we_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
            end
            if (go_resp) begin
                if (!in_range) begin
                    wb_dat_o <= 32'd0;
                end else if (!cur_we) begin
                    wb_dat_o <= mem[cur_idx];
                end
            end
        end
    end

    // Array kept free of reset so it maps onto a byte-enabled block RAM.
    logic mem_we;
    assign mem_we = go_resp & cur_we & in_range & ~wb_rst_i;

    always_ff @(posedge wb_clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb/tb_wb_ram_slave.sv - self-checking bench for wb_ram_slave (zero and three wait states)
module tb_wb_ram_slave;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    int          which;

    logic [31:0] dat0, dat3;
    logic        ack0, ack3, err0, err3;
    logic        cyc0, cyc3, stb0, stb3;

    assign cyc0 = cyc & (which == 0);
    assign stb0 = stb & (which == 0);
    assign cyc3 = cyc & (which == 1);
    assign stb3 = stb & (which == 1);

    wb_ram_slave #(.ADDR_WIDTH(10), .DEPTH_WORDS(1000), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_stb_i(stb0), .wb_cyc_i(cyc0),
        .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0)
    );

    wb_ram_slave #(.ADDR_WIDTH(10), .DEPTH_WORDS(1000), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_stb_i(stb3), .wb_cyc_i(cyc3),
        .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_err_o(err3)
    );

    logic        cur_ack, cur_err;
    logic [31:0] cur_dat;
    assign cur_ack = (which == 0) ? ack0 : ack3;
    assign cur_err = (which == 0) ? err0 : err3;
    assign cur_dat = (which == 0) ? dat0 : dat3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference memory per DUT, written only through whole-byte merges.
    logic [31:0] mdl [2][1024];
    int          wait_of [2] = '{0, 3};

    function automatic void model_write(input int w, input int idx, input logic [31:0] d, input logic [3:0] s);
        if (idx < 1000) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mdl[w][idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    task automatic xfer(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic ack_s, output logic err_s,
                        output logic [31:0] rd, output int lat);
        @(negedge clk);
        which = w; adr = a; wdat = d; sel = s; we = wr; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        ack_s = 1'b0; err_s = 1'b0; rd = 32'd0; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (cur_ack || cur_err) begin
                ack_s = cur_ack; err_s = cur_err; rd = cur_dat; lat = i;
                break;
            end
            @(posedge clk);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        #1;
        check("single_cycle_resp", {30'd0, cur_ack, cur_err}, 32'd0);
    endtask

    typedef struct {
        int          w;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [16];

    logic        g_ack, g_err;
    logic [31:0] g_rd;
    int          g_lat;

    initial begin
        which = 0; adr = 0; wdat = 0; sel = 0; we = 0; stb = 0; cyc = 0;
        rst = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_err0", {31'd0, err0}, 32'd0);
        check("rst_dat0", dat0, 32'd0);
        check("rst_ack3", {31'd0, ack3}, 32'd0);
        check("rst_dat3", dat3, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the reference memory, words 0..15 plus out-of-range
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) begin
                logic [31:0] d;
                d = $urandom;
                xfer(w, 1'b1, i * 4, d, 4'hF, g_ack, g_err, g_rd, g_lat);
                model_write(w, i, d, 4'hF);
                check("rnd_init_ack", {31'd0, g_ack}, 32'd1);
            end
            for (int n = 0; n < 40; n++) begin
                int          idx;
                logic        wr;
                logic [31:0] d, a;
                logic [3:0]  s;
                idx = ($urandom_range(0, 9) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 15);
                wr  = $urandom_range(0, 1) == 1;
                d   = $urandom;
                s   = 4'($urandom_range(0, 15));
                a   = {$urandom_range(0, 1048575), 12'd0} | (idx * 4) | $urandom_range(0, 3);
                xfer(w, wr, a, d, s, g_ack, g_err, g_rd, g_lat);
                check("rnd_lat", g_lat, 1 + wait_of[w]);
                if (idx >= 1000) begin
                    check("rnd_oor_err", {30'd0, g_ack, g_err}, 32'd1);
                    check("rnd_oor_dat", g_rd, 32'd0);
                end else begin
                    check("rnd_ack", {30'd0, g_ack, g_err}, 32'd2);
                    if (wr) model_write(w, idx, d, s);
                    else    check("rnd_rdata", g_rd, mdl[w][idx]);
                end
            end
        end

        // Directed vectors
        vecs[0]  = '{0, 1'b1, 32'h10,        32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'h10,        32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{0, 1'b1, 32'h20,        32'h11223344, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{0, 1'b1, 32'h20,        32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{0, 1'b0, 32'h20,        32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h11BB33DD};
        vecs[5]  = '{0, 1'b1, 32'h20,        32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{0, 1'b0, 32'h20,        32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 32'h11BB33DD};
        vecs[7]  = '{0, 1'b1, 32'h0,         32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{0, 1'b1, 32'hFA0,       32'h12345678, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[9]  = '{0, 1'b0, 32'h0,         32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[10] = '{0, 1'b0, 32'hFA0,       32'h0,        4'hF, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[11] = '{0, 1'b0, 32'hFFFFF013,  32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[12] = '{1, 1'b1, 32'h40,        32'h00000055, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1, 1'b0, 32'h40,        32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h00000055};
        vecs[14] = '{1, 1'b1, 32'h44,        32'h0BADF00D, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[15] = '{1, 1'b0, 32'hFA0,       32'h0,        4'hF, 1'b0, 1'b1, 1'b1, 32'h0};

        for (int i = 0; i < 16; i++) begin
            xfer(vecs[i].w, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].s, g_ack, g_err, g_rd, g_lat);
            check($sformatf("vec%0d_ack", i), {31'd0, g_ack}, {31'd0, vecs[i].exp_ack});
            check($sformatf("vec%0d_err", i), {31'd0, g_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i), g_lat, 1 + wait_of[vecs[i].w]);
            if (vecs[i].chk_dat) check($sformatf("vec%0d_dat", i), g_rd, vecs[i].exp_dat);
            if (vecs[i].wr && vecs[i].exp_ack) model_write(vecs[i].w, int'(vecs[i].a[11:2]), vecs[i].d, vecs[i].s);
        end

        // Abort during wait states: cyc low sampled at edge k+2
        @(negedge clk);
        which = 1; adr = 32'h44; wdat = 32'h00000055; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (ack3 || err3) seen++;
            end
            check("abort_no_resp", seen, 0);
        end
        xfer(1, 1'b0, 32'h44, 32'h0, 4'hF, g_ack, g_err, g_rd, g_lat);
        check("abort_old_value", g_rd, 32'h0BADF00D);

        // Reset asserted in the RESP cycle
        @(negedge clk);
        which = 0; adr = 32'h10; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        check("resp_before_rst", {31'd0, ack0}, 32'd1);
        rst = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                if (ack0 || err0) seen++;
            end
            cyc = 1'b0; stb = 1'b0;
            check("rst_in_resp_no_ack", seen, 0);
            check("rst_in_resp_dat", dat0, 32'd0);
        end

        // Reset during wait states discards the write
        @(negedge clk);
        rst = 1'b0;
        which = 1; adr = 32'h40; wdat = 32'h00000077; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, g_ack, g_err, g_rd, g_lat);
        check("rst_wait_no_write", g_rd, 32'h00000055);

        // Back-to-back reads of words 0..3 with stb held high
        begin
            int acks, consec, k, cyc_cnt;
            logic prev;
            acks = 0; consec = 0; k = 0; prev = 1'b0; cyc_cnt = 0;
            @(negedge clk);
            which = 0; adr = 32'h0; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
            while (acks < 4 && cyc_cnt < 20) begin
                @(posedge clk);
                #1;
                cyc_cnt++;
                if (ack0 && prev) consec++;
                prev = ack0;
                if (ack0) begin
                    check($sformatf("b2b_dat%0d", k), dat0, mdl[0][k]);
                    acks++;
                    k++;
                    adr = k * 4;
                end
            end
            cyc = 1'b0; stb = 1'b0;
            check("b2b_acks", acks, 4);
            check("b2b_consecutive", consec, 0);
            check("b2b_cycles", cyc_cnt, 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
